// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter that owns one single-port memory's pins.
// Define LOCK_EN to add lock0/lock1 burst-lock inputs that hold priority.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MEM_SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
`ifdef LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              oob_err
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_SIZE);

  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rd0_q, rd0_d, rd1_q, rd1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              rd_live_q, rd_live_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_en_q, mem_rd_en_d, mem_wr_en_q, mem_wr_en_d;
  logic              oob_err_q, oob_err_d;

  logic              elig0, elig1, lock_hold, any_gnt, sel_we, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    lock_hold = 1'b0;
    // A requester whose grant is showing this cycle is masked so a held req is not granted twice.
    elig0 = req0 & ~gnt0_q;
    elig1 = req1 & ~gnt1_q;
`ifdef LOCK_EN
    lock_hold = last_q ? (lock1 & req1) : (lock0 & req0);
`endif
    if (lock_hold) begin
      if (last_q) gnt1_d = elig1;
      else        gnt0_d = elig0;
    end else if (elig0 && elig1) begin
      // last_q names the requester served most recently; the other one wins.
      gnt0_d = last_q;
      gnt1_d = ~last_q;
    end else begin
      gnt0_d = elig0;
      gnt1_d = elig1;
    end

    any_gnt   = gnt0_d | gnt1_d;
    sel_addr  = gnt1_d ? addr1  : addr0;
    sel_wdata = gnt1_d ? wdata1 : wdata0;
    sel_we    = gnt1_d ? we1    : we0;
    in_range  = sel_addr < MEM_LIMIT;

    last_d      = gnt0_d ? 1'b0 : (gnt1_d ? 1'b1 : last_q);
    mem_addr_d  = any_gnt ? sel_addr  : mem_addr_q;
    mem_wdata_d = any_gnt ? sel_wdata : mem_wdata_q;
    mem_wr_en_d = any_gnt & in_range & sel_we;
    mem_rd_en_d = any_gnt & in_range & ~sel_we;
    oob_err_d   = any_gnt & ~in_range;

    // Reads (including squashed out-of-range ones) return one cycle after the grant.
    rd0_d     = gnt0_d & ~we0;
    rd1_d     = gnt1_d & ~we1;
    rvalid0_d = rd0_q;
    rvalid1_d = rd1_q;
    rd_live_d = mem_rd_en_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rd0_q       <= 1'b0;
      rd1_q       <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rd_live_q   <= 1'b0;
      last_q      <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      oob_err_q   <= 1'b0;
    end else begin
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rd_live_q   <= rd_live_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      oob_err_q   <= oob_err_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = (rvalid0_q & rd_live_q) ? mem_rdata : '0;
  assign rdata1    = (rvalid1_q & rd_live_q) ? mem_rdata : '0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign oob_err   = oob_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency memory.
// Define LOCK_EN to also exercise the lock ports.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [15:0] mem_addr;
  logic        mem_rd_en, mem_wr_en, oob_err;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef LOCK_EN
  logic        lock0, lock1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_SIZE(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .oob_err(oob_err)
  );

  // Memory: unwritten words read back as {A5A5, address}.
  logic [31:0] mem_arr [0:63];
  logic [63:0] wr_mask  = '0;
  int          wr_count = 0;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem_arr[mem_addr[5:0]] <= mem_wdata;
      wr_mask[mem_addr[5:0]] <= 1'b1;
      wr_count               <= wr_count + 1;
    end
    if (mem_rd_en)
      mem_rdata <= wr_mask[mem_addr[5:0]] ? mem_arr[mem_addr[5:0]] : {16'hA5A5, mem_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    rst = 1'b1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
`ifdef LOCK_EN
    lock0 = 0; lock1 = 0;
`endif
    do_reset();

    // Reset state
    check("rst_gnt",    {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check("rst_en",     {29'd0, oob_err, mem_wr_en, mem_rd_en}, 32'd0);
    check("rst_addr",   {16'd0, mem_addr}, 32'd0);
    check("rst_wdata",  mem_wdata, 32'd0);

    // Single write then read of address 5
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hDEADBEEF;
    tick();
    check("wr_gnt0",  {31'd0, gnt0}, 32'd1);
    check("wr_en",    {31'd0, mem_wr_en}, 32'd1);
    check("wr_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("wr_addr",  {16'd0, mem_addr}, 32'd5);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    we0 = 0;
    tick();
    check("wr_masked_gnt0", {31'd0, gnt0}, 32'd0);
    check("idle_wr_en",     {31'd0, mem_wr_en}, 32'd0);
    check("idle_addr_hold", {16'd0, mem_addr}, 32'd5);
    tick();
    check("rd_gnt0",  {31'd0, gnt0}, 32'd1);
    check("rd_en",    {31'd0, mem_rd_en}, 32'd1);
    check("rd_no_rv", {31'd0, rvalid0}, 32'd0);
    req0 = 0;
    tick();
    check("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
    check("rd_rdata0",  rdata0, 32'hDEADBEEF);
    check("rd_rvalid1", {31'd0, rvalid1}, 32'd0);
    tick();
    check("rd_rv_drop", {31'd0, rvalid0}, 32'd0);
    check("rd_rdata_0", rdata0, 32'd0);

    // Contention after reset: order 0,1,0,1
    do_reset();
    req0 = 1; addr0 = 1; req1 = 1; addr1 = 2;
    tick();
    check("ct1_gnt", {30'd0, gnt1, gnt0}, 32'b01);
    tick();
    check("ct2_gnt",  {30'd0, gnt1, gnt0}, 32'b10);
    check("ct2_rv0",  {31'd0, rvalid0}, 32'd1);
    check("ct2_rd0",  rdata0, 32'hA5A50001);
    tick();
    check("ct3_gnt",  {30'd0, gnt1, gnt0}, 32'b01);
    check("ct3_rv1",  {31'd0, rvalid1}, 32'd1);
    check("ct3_rd1",  rdata1, 32'hA5A50002);
    check("ct3_rd0z", rdata0, 32'd0);
    tick();
    check("ct4_gnt", {30'd0, gnt1, gnt0}, 32'b10);
    req0 = 0; req1 = 0;
    tick();
    check("ct5_gnt", {30'd0, gnt1, gnt0}, 32'b00);
    check("ct5_rv1", {31'd0, rvalid1}, 32'd1);
    tick();
    tick();

    // Single requester back-to-back: grant every second cycle
    req1 = 1; addr1 = 10; grants = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("b2b_gnt1", {31'd0, gnt1}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 1) check("b2b_rdata1", rdata1, {16'hA5A5, 16'(10 + c / 2)});
      if (gnt1) begin
        grants++;
        addr1 = addr1 + 16'd1;
      end
    end
    check("b2b_count", 32'(grants), 32'd3);
    req1 = 0;
    tick();
    tick();

    // Out-of-range read squashed, rvalid still returned with zero data
    req0 = 1; we0 = 0; addr0 = 64;
    tick();
    check("oob_gnt0",  {31'd0, gnt0}, 32'd1);
    check("oob_err",   {31'd0, oob_err}, 32'd1);
    check("oob_rd_en", {31'd0, mem_rd_en}, 32'd0);
    req0 = 0;
    tick();
    check("oob_rv0",      {31'd0, rvalid0}, 32'd1);
    check("oob_rdata0",   rdata0, 32'd0);
    check("oob_err_drop", {31'd0, oob_err}, 32'd0);

    // Out-of-range write causes no memory write
    grants = wr_count;
    req1 = 1; we1 = 1; addr1 = 100; wdata1 = 32'h12345678;
    tick();
    check("oobw_gnt1",  {31'd0, gnt1}, 32'd1);
    check("oobw_err",   {31'd0, oob_err}, 32'd1);
    check("oobw_wr_en", {31'd0, mem_wr_en}, 32'd0);
    req1 = 0; we1 = 0;
    tick();
    check("oobw_no_rv",  {31'd0, rvalid1}, 32'd0);
    check("oobw_no_wr",  32'(wr_count - grants), 32'd0);

    // Reset asserted in the grant cycle of a read
    req0 = 1; addr0 = 3;
    tick();
    check("rm_gnt0", {31'd0, gnt0}, 32'd1);
    rst = 1; req0 = 0;
    tick();
    check("rm_out0", {26'd0, gnt0, gnt1, rvalid0, mem_rd_en, mem_wr_en, oob_err}, 32'd0);
    check("rm_addr", {16'd0, mem_addr}, 32'd0);
    rst = 0;
    tick();
    check("rm_no_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
    req0 = 1; addr0 = 7; req1 = 1; addr1 = 8;
    tick();
    check("rm_first_ct", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 0; req1 = 0;
    tick();
    tick();
    tick();

`ifdef LOCK_EN
    // Lock keeps requester 0 in charge until released
    do_reset();
    lock0 = 1; req0 = 1; addr0 = 4; req1 = 1; addr1 = 6;
    tick();
    check("lk1_gnt", {30'd0, gnt1, gnt0}, 32'b01);
    tick();
    check("lk2_gnt", {30'd0, gnt1, gnt0}, 32'b00);
    tick();
    check("lk3_gnt", {30'd0, gnt1, gnt0}, 32'b01);
    lock0 = 0;
    tick();
    check("lk4_gnt", {30'd0, gnt1, gnt0}, 32'b10);
    req0 = 0; req1 = 0;
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port 32-bit memory (instruction or data store) between two requesters.
- Requester 0: the UART load/dump controller.
- Requester 1: the knapsack compute core.
- Round-robin arbitration, one access per grant, fixed read latency, out-of-range squashing.
- Sits between the requesters and the mem instance; owns the mem's addr/rd_en/wr_en/wdata pins exclusively.

Parameters:
ADDR_W, 16, address width of requester and memory address buses
DATA_W, 32, data word width
MEM_SIZE, 64, number of valid words; addresses >= MEM_SIZE are out of range

Ports:
clk  in  1  clock
rst  in  1  reset
req0  in  1  requester 0 access request; held until gnt0 seen
we0  in  1  requester 0: 1=write, 0=read; stable while req0
addr0  in  ADDR_W  requester 0 word address; stable while req0
wdata0  in  DATA_W  requester 0 write data; stable while req0
gnt0  out  1  one-cycle grant pulse to requester 0
rvalid0  out  1  read data valid for requester 0
rdata0  out  DATA_W  read data for requester 0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
mem_addr  out  ADDR_W  memory address
mem_rd_en  out  1  memory read enable
mem_wr_en  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd_en
oob_err  out  1  one-cycle pulse when a granted access is out of range

Behaviour:
- Reset: clk, rst; rst is synchronous, active-high.
  - All outputs are registered except rdata0/rdata1.
  - On rst: gnt*, rvalid*, mem_rd_en, mem_wr_en, oob_err = 0; mem_addr, mem_wdata = 0.
  - Round-robin pointer set so requester 0 wins the first contention.
  - Any pending rvalid is discarded.
- Arbitration, evaluated at each rising edge when not in reset:
  - A requester is eligible if its req is high and its gnt is not currently high. The gnt-high cycle is masked so a held req is never double-granted.
  - One eligible requester: grant it.
  - Both eligible: grant the requester not served most recently. Pointer updates on every grant.
- Grant cycle (cycle k+1 after req sampled at edge k):
  - gntN = 1 for exactly one cycle.
  - mem_addr = addrN; mem_wdata = wdataN.
  - mem_wr_en = weN; mem_rd_en = ~weN.
- Read return: cycle k+2.
  - rvalidN = 1 for one cycle.
  - rdataN = mem_rdata combinationally while rvalidN = 1; otherwise 0.
- Writes produce no rvalid.
- Throughput:
  - Alternating requesters: 1 access/cycle.
  - Single requester: 1 access per 2 cycles (req sampled, gnt, re-sample).
- Out of range (addrN >= MEM_SIZE):
  - gntN is still issued; mem_rd_en and mem_wr_en stay 0; oob_err pulses in the grant cycle.
  - Read: rvalidN still pulses at k+2 with rdataN = 0.
- Requester protocol: after seeing gntN at an edge, the requester drops req or presents the next access. Changing we/addr/wdata while req is high and ungranted is illegal (undefined result).
- Idle cycles: mem_rd_en and mem_wr_en = 0. mem_addr and mem_wdata hold their last value.
- rst asserted mid-access: any grant or rvalid due after the rst edge is suppressed; no memory write occurs after the rst edge.

Optional Feature:
LOCK_EN
- Enabled: adds inputs lock0 and lock1.
  - If the last-granted requester has lockN = 1 and reqN = 1 when sampled, it keeps priority over the other requester regardless of the pointer, for burst load/dump.
  - The gnt-cycle masking rule still applies.
  - The pointer is not updated while a lock holds.
- Disabled: no lock ports; pure round-robin.

Test Plan:
- Single write then read: req0, we0 = 1, addr0 = 5, wdata0 = 0xDEADBEEF. Then req0 read, addr0 = 5. Required: gnt0 one cycle after req; mem_wr_en = 1 with mem_addr = 5; later rvalid0 with rdata0 = 0xDEADBEEF two cycles after the read req is sampled.
- Contention: req0 and req1 both held for 4 reads after reset. Required: grant order 0,1,0,1; gnt pulses one cycle apart; never both gnt high.
- Single requester back-to-back: req1 held constantly, addr1 incrementing on each gnt1. Required: gnt1 every 2nd cycle; no duplicate grants.
- Out of range: req0 read, addr0 = 64. Required: gnt0 = 1, oob_err = 1, mem_rd_en = 0; rvalid0 = 1 with rdata0 = 0 next cycle. Write to addr1 = 100 leaves memory contents unchanged.
- Reset mid-access: assert rst in the grant cycle of a read. Required: no rvalid afterward; all outputs 0; after release, the first contention goes to requester 0.
- LOCK_EN: lock0 = 1 with req0 and req1 both held. Required: only requester 0 is granted until lock0 = 0; then requester 1 is granted next.
